pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshake.
//   Successor to the fixed 4-bit combinational ripple adder: any WIDTH, split into SEG-bit
//   ripple segments with a register stage between segments; adds subtract mode and signed overflow.
//   Sits on datapaths where a full-width ripple chain would not close timing;
//   sustains one operation per clock.
// PARAMETERS
//   WIDTH   16  operand/result width in bits; must be >= 1
//   SEG      4  bits per pipeline segment; WIDTH % SEG == 0 required (elaboration error otherwise)
//   STAGES = WIDTH/SEG (localparam): number of pipeline stages = latency in clocks
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set on a/b/cin/sub is valid
//   in_ready   out  1      block can accept operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in; used only when sub=0
//   sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1; cin ignored)
//   out_valid  out  1      result on sum/cout/ovf is valid
//   out_ready  in   1      downstream accepts result this cycle
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub=1: 1 = no borrow, i.e. a >= b unsigned)
//   ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Handshake: transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//   - advance = !out_valid | out_ready; in_ready = advance (combinational from out_ready, no other path).
//   - Whole pipeline moves as one: on advance every stage register loads from its predecessor,
//     each stage valid bit loads predecessor valid (stage 0 loads in_valid). !advance: all hold.
//   - Stage k (0..STAGES-1): SEG-bit ripple add of a[k*SEG +: SEG] and b'[k*SEG +: SEG]
//     (b' = sub ? ~b : b) with carry from stage k-1 register (stage 0: sub ? 1 : cin).
//   - Unprocessed upper operand bits skewed forward; completed lower sum bits de-skewed forward,
//     so all bits of one operation leave together. No operation mixes bits of another.
//   - Latency: STAGES clocks from accept to out_valid with no stalls; throughput 1/clk.
//   - Last stage registers sum, cout, ovf; outputs are registers, stable while out_valid & !out_ready.
//   - Bubbles (in_valid=0 on advance) propagate as invalid slots; they are not compacted.
//   - Ordering: results emerge strictly in acceptance order; none dropped or duplicated.
//   - Reset (any cycle, incl. mid-stream): next edge clears all valid bits, out_valid=0,
//     sum=0, cout=0, ovf=0; in-flight ops discarded. in_ready=1 during and after reset.
//   - STAGES=1 (SEG=WIDTH): single registered stage, latency 1, same handshake.
//   - WIDTH=1: ovf = carry-in to bit 0 XOR cout.
//   - in_valid while !in_ready: inputs ignored; upstream must hold them (no capture).
// TESTING
//   1 W16/S4: a=FFFF b=0001 cin=0 sub=0 -> 4 clk later sum=0000 cout=1 ovf=0
//   2 sub=1: a=0005 b=0007 -> sum=FFFE cout=0 ovf=0; a=8000 b=0001 -> sum=7FFF cout=1 ovf=1
//   3 8 back-to-back ops, out_ready=1 -> 8 results on 8 consecutive clks, in order, latency 4
//   4 out_ready=0 for 3 clks mid-stream -> in_ready=0 those clks, sum/cout/ovf held; no loss/dup
//   5 rst for 1 clk with 3 ops in flight -> out_valid=0 next clk, none of the 3 ever emitted
//   6 10k random ops + random in_valid/out_ready vs golden model; W32/S8, W16/S16, W8/S1

Source files
------------

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit ripple add/subtract split into SEG-bit
// segments, one register stage per segment, valid/ready handshake.
module pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be >= 1 and a multiple of SEG");
    end

    // Each stage register carries the full operand pair (b already
    // conditioned for subtract), the partially built sum, the carry out
    // of the segment it just added and a valid bit.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             ovf_d;

    logic advance;

    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           c
    );
        return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
    endfunction

    // Per-stage segment adders: stage 0 from the ports, stage k from
    // the register of stage k-1, so one operation never mixes with another.
    always_comb begin
        logic [SEG:0] t;
        logic [WIDTH-1:0] bi;

        bi     = sub ? ~b : b;
        t      = seg_add(a[SEG-1:0], bi[SEG-1:0], sub | cin);
        a_d[0] = a;
        b_d[0] = bi;
        s_d[0] = '0;
        s_d[0][SEG-1:0] = t[SEG-1:0];
        c_d[0] = t[SEG];

        for (int k = 1; k < STAGES; k++) begin
            t      = seg_add(a_q[k-1][k*SEG +: SEG],
                             b_q[k-1][k*SEG +: SEG],
                             c_q[k-1]);
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            s_d[k][k*SEG +: SEG] = t[SEG-1:0];
            c_d[k] = t[SEG];
        end

        // Carry into the MSB is recovered from the MSB sum bit itself.
        ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1]
              ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    end

    // Whole pipeline shifts together on advance and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            ovf_q <= ovf_d;
        end
    end

    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed tests on a W16/S4 instance plus random
// traffic on several configurations against an arithmetic model.
module tb_pipelined_addsub;

    logic clk;
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} computed with integer arithmetic.
    function automatic logic [33:0] ref_op(input int w,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic cin,
                                           input logic sub);
        longint m, half, ua, ub, u, sa, sb, s;
        logic [31:0] r;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        u    = sub ? (ua - ub + m) : (ua + ub + longint'(cin));
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        s    = sub ? (sa - sb) : (sa + sb + longint'(cin));
        r    = 32'(u % m);
        return {(s < -half) || (s >= half), u >= m, r};
    endfunction

    // ---------------- directed instance ----------------
    logic        d_rst, d_iv, d_ir, d_ov, d_ordy, d_cin, d_sub, d_co, d_of;
    logic [15:0] d_a, d_b, d_sum;
    logic [17:0] dq[$];

    pipelined_addsub #(.WIDTH(16), .SEG(4)) u_dir (
        .clk(clk), .rst(d_rst),
        .in_valid(d_iv), .in_ready(d_ir),
        .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
        .out_valid(d_ov), .out_ready(d_ordy),
        .sum(d_sum), .cout(d_co), .ovf(d_of)
    );

    function automatic logic [17:0] d_ref(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c, input logic s);
        logic [33:0] r;
        r = ref_op(16, 32'(a), 32'(b), c, s);
        return {r[33], r[32], r[15:0]};
    endfunction

    task automatic d_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic c,
                        input logic s, input logic [17:0] exp);
        int lat;
        d_a = a; d_b = b; d_cin = c; d_sub = s;
        d_iv = 1'b1; d_ordy = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        lat = 1;
        while (!d_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check(tag, {46'd0, d_of, d_co, d_sum}, {46'd0, exp});
    endtask

    task automatic d_flush();
        d_iv = 1'b0; d_ordy = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < 5; g++) begin : gcfg
        localparam int W = (g == 0) ? 16 : (g == 1) ? 32 :
                           (g == 2) ? 16 : (g == 3) ? 8 : 1;
        localparam int S = (g == 0) ? 4 : (g == 1) ? 8 :
                           (g == 2) ? 16 : 1;
        localparam int NOPS = (g == 4) ? 500 : 2500;

        logic         rst, iv, ir, ov, ordy, rc, rs, co, of, done;
        logic [W-1:0] ra, rb, sm;
        logic [W+1:0] q[$];

        pipelined_addsub #(.WIDTH(W), .SEG(S)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(rc), .sub(rs),
            .out_valid(ov), .out_ready(ordy),
            .sum(sm), .cout(co), .ovf(of)
        );

        initial begin
            int acc, cyc;
            logic taken, stall;
            logic [W+2:0] held;
            logic [W+1:0] e;
            logic [33:0] r;
            done = 1'b0; rst = 1'b1; iv = 1'b0; ordy = 1'b0;
            ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
            acc = 0; cyc = 0; stall = 1'b0; held = '0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            while (acc < NOPS && cyc < 40000) begin
                taken = 1'b0;
                if (!iv && $urandom_range(0, 3) != 0) begin
                    iv = 1'b1;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                end
                ordy = ($urandom_range(0, 3) != 0);
                #1;
                if (stall)
                    check($sformatf("c%0d_hold", g),
                          64'({ov, of, co, sm}), 64'(held));
                stall = ov && !ordy;
                held  = {ov, of, co, sm};
                if (ov && ordy) begin
                    check($sformatf("c%0d_nonempty", g),
                          64'(q.size() > 0), 64'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check($sformatf("c%0d_out", g),
                              64'({of, co, sm}), 64'(e));
                    end
                end
                if (iv && ir) begin
                    r = ref_op(W, 32'(ra), 32'(rb), rc, rs);
                    q.push_back({r[33], r[32], r[W-1:0]});
                    acc++;
                    taken = 1'b1;
                end
                @(negedge clk);
                cyc++;
                if (taken) iv = 1'b0;
            end
            check($sformatf("c%0d_ops", g), 64'(acc), 64'(NOPS));
            iv = 1'b0; ordy = 1'b1; cyc = 0;
            while (q.size() != 0 && cyc < 100) begin
                #1;
                if (ov) begin
                    e = q.pop_front();
                    check($sformatf("c%0d_drain", g),
                          64'({of, co, sm}), 64'(e));
                end
                @(negedge clk);
                cyc++;
            end
            check($sformatf("c%0d_left", g), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence + summary ----------------
    initial begin
        int nout, sent, got, cnt, t;
        logic acc;
        logic [17:0] e, hold;

        d_rst = 1'b1; d_iv = 1'b0; d_ordy = 1'b0;
        d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0;
        repeat (2) @(negedge clk);
        d_rst = 1'b0;
        check("rst_ov", 64'(d_ov), 64'd0);
        check("rst_sum", 64'(d_sum), 64'd0);
        check("rst_cout", 64'(d_co), 64'd0);
        check("rst_ovf", 64'(d_of), 64'd0);
        check("rst_ready", 64'(d_ir), 64'd1);

        d_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        d_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        d_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        d_op("add_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h8000});
        d_op("sub_cin", 16'h0003, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});

        // back-to-back stream
        d_flush();
        dq.delete();
        nout = 0;
        for (int i = 0; i < 14; i++) begin
            d_ordy = 1'b1;
            if (d_ov) begin
                check("b2b_cycle", 64'(i), 64'(4 + nout));
                e = (dq.size() > 0) ? dq.pop_front() : 18'h3FFFF;
                check("b2b_val", {46'd0, d_of, d_co, d_sum}, {46'd0, e});
                nout++;
            end
            if (i < 8) begin
                d_a = 16'($urandom); d_b = 16'($urandom);
                d_cin = 1'($urandom); d_sub = 1'($urandom);
                d_iv = 1'b1;
                dq.push_back(d_ref(d_a, d_b, d_cin, d_sub));
            end else begin
                d_iv = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_count", 64'(nout), 64'd8);

        // stall mid-stream
        d_flush();
        dq.delete();
        sent = 0; got = 0; hold = '0;
        for (int i = 0; i < 25; i++) begin
            acc = 1'b0;
            if (!d_iv && sent < 10) begin
                d_a = 16'($urandom); d_b = 16'($urandom);
                d_cin = 1'($urandom); d_sub = 1'($urandom);
                d_iv = 1'b1;
            end
            d_ordy = !(i >= 6 && i <= 8);
            #1;
            if (i >= 6 && i <= 8) begin
                check("stall_ready", 64'(d_ir), 64'd0);
                check("stall_valid", 64'(d_ov), 64'd1);
            end
            if (i == 6) hold = {d_of, d_co, d_sum};
            if (i == 7 || i == 8)
                check("stall_hold", {46'd0, d_of, d_co, d_sum}, {46'd0, hold});
            if (d_ov && d_ordy) begin
                e = (dq.size() > 0) ? dq.pop_front() : 18'h3FFFF;
                check("stall_val", {46'd0, d_of, d_co, d_sum}, {46'd0, e});
                got++;
            end
            if (d_iv && d_ir) begin
                dq.push_back(d_ref(d_a, d_b, d_cin, d_sub));
                sent++;
                acc = 1'b1;
            end
            @(negedge clk);
            if (acc) d_iv = 1'b0;
        end
        check("stall_count", 64'(got), 64'd10);

        // reset with three operations in flight
        d_flush();
        for (int i = 0; i < 3; i++) begin
            d_a = 16'($urandom); d_b = 16'($urandom);
            d_cin = 1'b0; d_sub = 1'b0; d_iv = 1'b1;
            @(negedge clk);
        end
        d_iv = 1'b0; d_rst = 1'b1;
        @(negedge clk);
        d_rst = 1'b0;
        check("mid_rst_ov", 64'(d_ov), 64'd0);
        check("mid_rst_sum", 64'(d_sum), 64'd0);
        check("mid_rst_cout", 64'(d_co), 64'd0);
        check("mid_rst_ovf", 64'(d_of), 64'd0);
        check("mid_rst_ready", 64'(d_ir), 64'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (d_ov) cnt++;
            @(negedge clk);
        end
        check("mid_rst_none", 64'(cnt), 64'd0);

        t = 0;
        while (!(gcfg[0].done & gcfg[1].done & gcfg[2].done &
                 gcfg[3].done & gcfg[4].done) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        check("rnd_done", 64'(gcfg[0].done & gcfg[1].done & gcfg[2].done &
                              gcfg[3].done & gcfg[4].done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
